// File: rtl/spi_slave_frame_rx.sv
// SPI mode-3 slave: oversampled deserialiser plus AA 55 framed command parser driving a 16-bit write port.
// Optional MISO echo of the previous byte is built when SPI_SLAVE_MISO_ECHO_EN is defined.
module spi_slave_frame_rx #(
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic [7:0]        rx_byte,
  output logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [15:0]       cfg_len,
  output logic              frame_err,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE, HDR, TYPE, LEN_H, LEN_L, ADDR_H, ADDR_L, DATA_H, DATA_L
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_prev, cs_prev;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, cs_rise, byte_done;
  logic [6:0]             shreg;
  logic [2:0]             bit_cnt;
  state_t                 state;
  logic [7:0]             hi_byte;
  logic [ADDR_W-1:0]      addr_reg, ptr;
  logic [15:0]            word_cnt;

  // Stage: input synchronisers and edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b1;
      cs_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_prev  <= sck_s;
      cs_prev   <= cs_s;
    end
  end

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign byte_done = ~cs_s & sck_rise & (bit_cnt == 3'd7);

  // Stage: MSB-first deserialiser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shreg   <= {shreg[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          rx_byte  <= {shreg, mosi_s};
          rx_valid <= 1'b1;
        end
      end
    end
  end

  // Stage: frame parser, one step per received byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      hi_byte   <= '0;
      addr_reg  <= '0;
      ptr       <= '0;
      word_cnt  <= '0;
      cfg_len   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      // Deasserting CS mid-frame or mid-byte aborts; a pending data hi byte is dropped.
      if (cs_rise && (state != IDLE || bit_cnt != 3'd0)) begin
        state     <= IDLE;
        busy      <= 1'b0;
        frame_err <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_byte == 8'hAA) begin
              state <= HDR;
              busy  <= 1'b1;
            end
          end
          HDR: begin
            if (rx_byte == 8'h55) begin
              state <= TYPE;
            end else if (rx_byte != 8'hAA) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          TYPE: begin
            case (rx_byte)
              8'hA4: state <= LEN_H;
              8'hA5: state <= ADDR_H;
              8'hA6: begin
                if (cfg_len != 16'd0) begin
                  state    <= DATA_H;
                  ptr      <= addr_reg;
                  word_cnt <= '0;
                end else begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  frame_err <= 1'b1;
                end
              end
              default: begin
                state     <= IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
              end
            endcase
          end
          LEN_H: begin
            hi_byte <= rx_byte;
            state   <= LEN_L;
          end
          LEN_L: begin
            cfg_len <= {hi_byte, rx_byte};
            state   <= IDLE;
            busy    <= 1'b0;
          end
          ADDR_H: begin
            hi_byte <= rx_byte;
            state   <= ADDR_L;
          end
          ADDR_L: begin
            addr_reg <= ADDR_W'({hi_byte, rx_byte});
            state    <= IDLE;
            busy     <= 1'b0;
          end
          DATA_H: begin
            hi_byte <= rx_byte;
            state   <= DATA_L;
          end
          DATA_L: begin
            wr_en    <= 1'b1;
            wr_addr  <= ptr;
            wr_data  <= {hi_byte, rx_byte};
            ptr      <= ptr + 1'b1;
            word_cnt <= word_cnt + 16'd1;
            if (word_cnt + 16'd1 == cfg_len) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA_H;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SPI_SLAVE_MISO_ECHO_EN
  logic [7:0] tx_sr;
  logic       sck_fall;

  assign sck_fall = ~sck_s & sck_prev;

  // Stage: echo shifter; the first fall of each byte keeps the MSB so it is sampled on the first rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr <= '0;
    end else if (cs_s) begin
      tx_sr <= '0;
    end else if (byte_done) begin
      tx_sr <= {shreg, mosi_s};
    end else if (sck_fall && bit_cnt != 3'd0) begin
      tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

  assign miso = cs_s | tx_sr[7];
`else
  assign miso = 1'b1;
`endif

endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// Directed, table-driven bench for spi_slave_frame_rx with hand-written abort, reset and echo sequences.
module tb_spi_slave_frame_rx;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cs_n = 1'b1;
  logic              sck = 1'b1;
  logic              mosi = 1'b0;
  logic              miso;
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [15:0]       cfg_len;
  logic              frame_err;
  logic              busy;

  always #5 clk = ~clk;

  spi_slave_frame_rx #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck), .mosi(mosi), .miso(miso),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cfg_len(cfg_len), .frame_err(frame_err), .busy(busy)
  );

  typedef struct {
    bit           do_rst;
    int           n;
    logic [143:0] bytes;
    int           exp_wr;
    logic [9:0]   a0;
    logic [15:0]  d0;
    logic [9:0]   a1;
    logic [15:0]  d1;
    logic [15:0]  len;
    int           exp_err;
  } vec_t;

  vec_t vecs[7];

  int errors = 0;
  int checks = 0;
  int n_wr = 0, n_err = 0, n_rx = 0;
  logic [ADDR_W-1:0] wa[0:15];
  logic [15:0]       wd[0:15];
  logic [7:0]        echo_sr = 8'h00;

  always @(negedge clk) begin
    if (wr_en) begin
      if (n_wr < 16) begin
        wa[n_wr] = wr_addr;
        wd[n_wr] = wr_data;
      end
      n_wr++;
    end
    if (frame_err) n_err++;
    if (rx_valid) n_rx++;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_wr = 0;
    n_err = 0;
    n_rx = 0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk); sck = 1'b0; mosi = b[i];
      repeat (3) @(negedge clk);
      @(negedge clk); echo_sr = {echo_sr[6:0], miso}; sck = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic run_frame(input int n, input logic [143:0] bytes);
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) send_bits(bytes[8*(n-1-i) +: 8], 8);
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_miso"}, miso, 1);
    chk({tag, "_rx_byte"}, rx_byte, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_cfg_len"}, cfg_len, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    vecs[0] = '{0, 18, 144'hAA55A40002AA55A50102AA55A60102030405, 2, 10'h102, 16'h0102, 10'h103, 16'h0304, 16'd2, 0};
    vecs[1] = '{0, 8, 144'hAA55A7AA55A40001, 0, 10'h0, 16'h0, 10'h0, 16'h0, 16'd1, 1};
    vecs[2] = '{1, 3, 144'hAA55A6, 0, 10'h0, 16'h0, 10'h0, 16'h0, 16'd0, 1};
    vecs[3] = '{0, 17, 144'hAA55A503FFAA55A40002AA55A611223344, 2, 10'h3FF, 16'h1122, 10'h000, 16'h3344, 16'd2, 0};
    vecs[4] = '{0, 7, 144'hAAAA55A4000300, 0, 10'h0, 16'h0, 10'h0, 16'h0, 16'd3, 0};
    vecs[5] = '{0, 14, 144'hAA55A50010AA55A6000100020003, 3, 10'h010, 16'h0001, 10'h012, 16'h0003, 16'd3, 0};
    vecs[6] = '{0, 4, 144'h123455A4, 0, 10'h0, 16'h0, 10'h0, 16'h0, 16'd3, 0};

    repeat (3) @(negedge clk);
    chk_reset_values("por");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].do_rst) do_reset();
      clear_counts();
      run_frame(vecs[v].n, vecs[v].bytes);
      chk($sformatf("v%0d_cfg_len", v), cfg_len, vecs[v].len);
      chk($sformatf("v%0d_n_wr", v), n_wr, vecs[v].exp_wr);
      chk($sformatf("v%0d_n_err", v), n_err, vecs[v].exp_err);
      chk($sformatf("v%0d_n_rx", v), n_rx, vecs[v].n);
      chk($sformatf("v%0d_rx_byte", v), rx_byte, vecs[v].bytes[7:0]);
      chk($sformatf("v%0d_busy", v), busy, 0);
      if (vecs[v].exp_wr > 0) begin
        chk($sformatf("v%0d_addr_first", v), wa[0], vecs[v].a0);
        chk($sformatf("v%0d_data_first", v), wd[0], vecs[v].d0);
      end
      if (vecs[v].exp_wr > 1 && vecs[v].exp_wr <= 16) begin
        chk($sformatf("v%0d_addr_last", v), wa[vecs[v].exp_wr-1], vecs[v].a1);
        chk($sformatf("v%0d_data_last", v), wd[vecs[v].exp_wr-1], vecs[v].d1);
      end
    end

    // Abort inside a data burst after only the hi byte
    clear_counts();
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'hAA, 8); send_bits(8'h55, 8); send_bits(8'hA6, 8); send_bits(8'h01, 8);
    repeat (8) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_err_cycles", n_err, 1);
    chk("abort_n_wr", n_wr, 0);
    chk("abort_busy_after", busy, 0);

    // CS released mid-byte while idle
    clear_counts();
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'hAA, 4);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("partial_err_cycles", n_err, 1);
    chk("partial_n_rx", n_rx, 0);

    // Reset asserted after four SCK edges, then a clean frame
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'hA5, 4);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    cs_n = 1'b1; sck = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    clear_counts();
    run_frame(5, 144'hAA55A40007);
    chk("post_rst_cfg_len", cfg_len, 16'd7);
    chk("post_rst_n_err", n_err, 0);
    chk("post_rst_n_rx", n_rx, 5);

    // MISO behaviour over two consecutive bytes
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'h3C, 8);
`ifdef SPI_SLAVE_MISO_ECHO_EN
    chk("echo_first", echo_sr, 8'h00);
    send_bits(8'hC3, 8);
    chk("echo_second", echo_sr, 8'h3C);
`else
    chk("miso_const_first", echo_sr, 8'hFF);
    send_bits(8'hC3, 8);
    chk("miso_const_second", echo_sr, 8'hFF);
`endif
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("miso_idle", miso, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
